// File: rtl/common_gnss_types_pkg.sv
// Shared GNSS types and constants: C/A code length, LFSR shapes and the
// G2 phase-selector table used by the code replica.
package common_gnss_types_pkg;

    localparam int L1CA_CODE_LEN = 1023;

    typedef logic [4:0]  sv_t;
    typedef logic [9:0]  gps_chip_t;
    typedef logic [10:1] l1ca_lfsr_t;

    localparam l1ca_lfsr_t L1CA_LFSR_INIT = '1;
    // Feedback tap masks, bit k of the mask selects stage k
    localparam l1ca_lfsr_t L1CA_G1_MASK   = 10'b10_0000_0100;
    localparam l1ca_lfsr_t L1CA_G2_MASK   = 10'b11_1010_0110;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } g2_tap_t;

    typedef enum logic [1:0] {
        L1CA_IDLE,
        L1CA_RUN,
        L1CA_SLEW
    } l1ca_state_t;

    function automatic g2_tap_t l1ca_g2_taps(input sv_t sv);
        g2_tap_t t;
        t = {4'd2, 4'd6};
        case (sv)
            5'd0:  t = {4'd2, 4'd6};
            5'd1:  t = {4'd3, 4'd7};
            5'd2:  t = {4'd4, 4'd8};
            5'd3:  t = {4'd5, 4'd9};
            5'd4:  t = {4'd1, 4'd9};
            5'd5:  t = {4'd2, 4'd10};
            5'd6:  t = {4'd1, 4'd8};
            5'd7:  t = {4'd2, 4'd9};
            5'd8:  t = {4'd3, 4'd10};
            5'd9:  t = {4'd2, 4'd3};
            5'd10: t = {4'd3, 4'd4};
            5'd11: t = {4'd5, 4'd6};
            5'd12: t = {4'd6, 4'd7};
            5'd13: t = {4'd7, 4'd8};
            5'd14: t = {4'd8, 4'd9};
            5'd15: t = {4'd9, 4'd10};
            5'd16: t = {4'd1, 4'd4};
            5'd17: t = {4'd2, 4'd5};
            5'd18: t = {4'd3, 4'd6};
            5'd19: t = {4'd4, 4'd7};
            5'd20: t = {4'd5, 4'd8};
            5'd21: t = {4'd6, 4'd9};
            5'd22: t = {4'd1, 4'd3};
            5'd23: t = {4'd4, 4'd6};
            5'd24: t = {4'd5, 4'd7};
            5'd25: t = {4'd6, 4'd8};
            5'd26: t = {4'd7, 4'd9};
            5'd27: t = {4'd8, 4'd10};
            5'd28: t = {4'd1, 4'd6};
            5'd29: t = {4'd2, 4'd7};
            5'd30: t = {4'd3, 4'd8};
            5'd31: t = {4'd4, 4'd9};
            default: t = {4'd2, 4'd6};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/l1ca_lfsr.sv
// Ten-stage Fibonacci LFSR with all-ones load; exposes its next state so the
// parent can register a chip derived from the post-update contents.
module l1ca_lfsr
    import common_gnss_types_pkg::*;
#(
    parameter l1ca_lfsr_t FB_MASK = L1CA_G1_MASK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    output l1ca_lfsr_t state_next
);

    l1ca_lfsr_t state;

    // Stage k moves to k+1; the parity of the tapped stages enters stage 1
    always_comb begin
        state_next = state;
        if (load)
            state_next = L1CA_LFSR_INIT;
        else if (shift)
            state_next = {state[9:1], ^(state & FB_MASK)};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= L1CA_LFSR_INIT;
        else
            state <= state_next;
    end

endmodule

// File: rtl/l1ca_code_gen.sv
// GPS L1 C/A code replica: one chip per chip_en, with restart on start and a
// slew hold that freezes the code for a requested number of strobes.
module l1ca_code_gen
    import common_gnss_types_pkg::*;
#(
    parameter int CODE_LEN = L1CA_CODE_LEN
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  sv_t       sv,
    input  logic      chip_en,
    input  logic      slew_valid,
    input  gps_chip_t slew_chips,
    output logic      slew_ready,
    output logic      chip,
    output gps_chip_t chip_idx,
    output logic      epoch,
    output logic      running
);

    localparam gps_chip_t LAST_IDX = gps_chip_t'(CODE_LEN - 1);

    l1ca_state_t state_q, state_d;
    sv_t         sv_q, sv_d;
    gps_chip_t   idx_d;
    gps_chip_t   hold_q, hold_d;
    logic        epoch_d;
    logic        chip_d;
    logic        lfsr_load, lfsr_shift;
    l1ca_lfsr_t  g1_next, g2_next;
    g2_tap_t     taps_d;

    assign slew_ready = (state_q == L1CA_RUN);
    assign running    = (state_q != L1CA_IDLE);

    l1ca_lfsr #(.FB_MASK(L1CA_G1_MASK)) u_g1 (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .shift      (lfsr_shift),
        .state_next (g1_next)
    );

    l1ca_lfsr #(.FB_MASK(L1CA_G2_MASK)) u_g2 (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .shift      (lfsr_shift),
        .state_next (g2_next)
    );

    always_comb begin
        state_d    = state_q;
        sv_d       = sv_q;
        idx_d      = chip_idx;
        hold_d     = hold_q;
        epoch_d    = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_shift = 1'b0;
        if (start) begin
            state_d   = L1CA_RUN;
            sv_d      = sv;
            idx_d     = '0;
            hold_d    = '0;
            lfsr_load = 1'b1;
        end else begin
            case (state_q)
                L1CA_RUN: begin
                    if (chip_en) begin
                        // Terminal chip wraps by reload rather than by shifting
                        if (chip_idx == LAST_IDX) begin
                            idx_d     = '0;
                            lfsr_load = 1'b1;
                            epoch_d   = 1'b1;
                        end else begin
                            idx_d      = chip_idx + 10'd1;
                            lfsr_shift = 1'b1;
                        end
                    end
                    if (slew_valid && (slew_chips != '0)) begin
                        hold_d  = slew_chips;
                        state_d = L1CA_SLEW;
                    end
                end
                L1CA_SLEW: begin
                    if (chip_en) begin
                        hold_d = hold_q - 10'd1;
                        if (hold_q == 10'd1)
                            state_d = L1CA_RUN;
                    end
                end
                default: ;
            endcase
        end
        taps_d = l1ca_g2_taps(sv_d);
        chip_d = (state_d != L1CA_IDLE) &&
                 (g1_next[10] ^ g2_next[taps_d.a] ^ g2_next[taps_d.b]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= L1CA_IDLE;
            sv_q     <= '0;
            chip_idx <= '0;
            hold_q   <= '0;
            epoch    <= 1'b0;
            chip     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sv_q     <= sv_d;
            chip_idx <= idx_d;
            hold_q   <= hold_d;
            epoch    <= epoch_d;
            chip     <= chip_d;
        end
    end

endmodule

// File: tb/tb_l1ca_code_gen.sv
// Bench for l1ca_code_gen: golden C/A codes from G1 and delayed-G2 sequences,
// a cycle model of the control behaviour, and directed plus random stimulus.
module tb_l1ca_code_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] sv = '0;
    logic       chip_en = 1'b0;
    logic       slew_valid = 1'b0;
    logic [9:0] slew_chips = '0;
    logic       slew_ready, chip, epoch, running;
    logic [9:0] chip_idx;

    int checks = 0;
    int failures = 0;

    l1ca_code_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sv         (sv),
        .chip_en    (chip_en),
        .slew_valid (slew_valid),
        .slew_chips (slew_chips),
        .slew_ready (slew_ready),
        .chip       (chip),
        .chip_idx   (chip_idx),
        .epoch      (epoch),
        .running    (running)
    );

    always #5 clk = ~clk;

    // G2 code-phase delays (chips) for PRN 1..32
    int dly [32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256,
                     257, 258, 469, 470, 471, 472, 473, 474, 509, 512, 513, 514,
                     515, 516, 859, 860, 861, 862};
    bit g1s [1033];
    bit g2s [1033];
    bit code [32][1023];
    bit gen_done = 1'b0;

    // Behavioural model state
    bit m_run = 0, m_slew = 0, m_epoch = 0;
    int m_idx = 0, m_hold = 0, m_prn = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_slew = 0; m_epoch = 0; m_idx = 0; m_hold = 0; m_prn = 0;
        end else if (start) begin
            m_run = 1; m_slew = 0; m_epoch = 0; m_idx = 0; m_hold = 0; m_prn = int'(sv);
        end else begin
            m_epoch = 0;
            if (m_run && !m_slew) begin
                if (chip_en) begin
                    m_idx = (m_idx + 1) % 1023;
                    m_epoch = (m_idx == 0);
                end
                if (slew_valid && slew_chips != 0) begin
                    m_slew = 1;
                    m_hold = int'(slew_chips);
                end
            end else if (m_slew && chip_en) begin
                m_hold--;
                if (m_hold == 0) m_slew = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (gen_done) begin
            chk("chip", int'(chip), m_run ? int'(code[m_prn][m_idx]) : 0);
            chk("chip_idx", int'(chip_idx), m_idx);
            chk("epoch", int'(epoch), int'(m_epoch));
            chk("running", int'(running), int'(m_run));
            chk("slew_ready", int'(slew_ready), int'(m_run && !m_slew));
        end
    end

    task automatic cyc(input bit s, input bit en, input int svv, input bit sv_valid, input int sn);
        start = s;
        chip_en = en;
        sv = svv[4:0];
        slew_valid = sv_valid;
        slew_chips = sn[9:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        chip_en = 1'b0;
        slew_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] w;
        logic [9:0] lit [4];
        int epochs, p, c0;
        lit[0] = 10'o1440; lit[1] = 10'o1620; lit[2] = 10'o1710; lit[3] = 10'o1744;

        for (int t = 0; t < 10; t++) begin g1s[t] = 1; g2s[t] = 1; end
        for (int t = 0; t < 1023; t++) begin
            g1s[t+10] = g1s[t+7] ^ g1s[t];
            g2s[t+10] = g2s[t+8] ^ g2s[t+7] ^ g2s[t+4] ^ g2s[t+2] ^ g2s[t+1] ^ g2s[t];
        end
        for (int q = 0; q < 32; q++)
            for (int t = 0; t < 1023; t++)
                code[q][t] = g1s[t] ^ g2s[(t - dly[q] + 1023) % 1023];
        gen_done = 1'b1;

        for (int q = 0; q < 4; q++) begin
            w = '0;
            for (int t = 0; t < 10; t++) w = {w[8:0], logic'(code[q][t])};
            chk("model_first10", int'(w), int'(lit[q]));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_idx", int'(chip_idx), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_chip", int'(chip), 0);
        chk("rst_ready", int'(slew_ready), 0);
        rst = 1'b0;
        cyc(0, 1, 0, 0, 0);
        chk("idle_idx", int'(chip_idx), 0);
        chk("idle_running", int'(running), 0);

        for (int q = 0; q < 4; q++) begin
            cyc(1, 0, q, 0, 0);
            w = {9'd0, chip};
            for (int t = 0; t < 9; t++) begin
                cyc(0, 1, q, 0, 0);
                w = {w[8:0], chip};
            end
            chk("dut_first10", int'(w), int'(lit[q]));
            if (q == 0) begin
                cyc(0, 1, q, 0, 0);
                chk("idx_after10", int'(chip_idx), 10);
            end
        end

        cyc(1, 0, 0, 0, 0);
        epochs = 0;
        for (int t = 0; t < 1023; t++) begin
            cyc(0, 1, 0, 0, 0);
            if (epoch) begin
                epochs++;
                chk("epoch_idx", int'(chip_idx), 0);
            end
        end
        chk("epoch_count", epochs, 1);
        for (int t = 0; t < 1023; t++) cyc(0, 1, 0, 0, 0);

        for (int q = 0; q < 32; q++) begin
            cyc(1, 0, q, 0, 0);
            for (int t = 0; t < 1023; t++) cyc(0, 1, q, 0, 0);
        end

        p = $urandom_range(0, 31);
        cyc(1, 0, p, 0, 0);
        repeat (5) cyc(0, 1, p, 0, 0);
        chk("slew_pre_idx", int'(chip_idx), 5);
        c0 = int'(chip);
        cyc(0, 0, p, 1, 3);
        chk("slew_ready_drop", int'(slew_ready), 0);
        for (int t = 0; t < 3; t++) begin
            cyc(0, 1, p, 0, 0);
            chk("slew_hold_idx", int'(chip_idx), 5);
            chk("slew_hold_chip", int'(chip), c0);
        end
        cyc(0, 1, p, 0, 0);
        chk("slew_resume_idx", int'(chip_idx), 6);
        chk("slew_resume_ready", int'(slew_ready), 1);

        cyc(0, 1, p, 1, 2);
        chk("slew_same_idx", int'(chip_idx), 7);
        chk("slew_same_ready", int'(slew_ready), 0);
        cyc(0, 1, p, 0, 0);
        cyc(0, 1, p, 0, 0);
        chk("slew_same_hold", int'(chip_idx), 7);
        cyc(0, 1, p, 0, 0);
        chk("slew_same_adv", int'(chip_idx), 8);
        cyc(0, 0, p, 1, 0);
        chk("slew_zero_ready", int'(slew_ready), 1);
        chk("slew_zero_idx", int'(chip_idx), 8);

        cyc(1, 1, (p + 1) % 32, 1, 4);
        chk("start_en_idx", int'(chip_idx), 0);
        chk("start_en_chip", int'(chip), 1);
        chk("start_en_ready", int'(slew_ready), 1);
        chk("start_en_epoch", int'(epoch), 0);

        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 5);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 7, 1, 2);
        chk("start_slew_idx", int'(chip_idx), 0);
        chk("start_slew_running", int'(running), 1);
        chk("start_slew_ready", int'(slew_ready), 1);
        chk("start_slew_epoch", int'(epoch), 0);
        cyc(0, 1, 20, 0, 0);
        chk("sv_ignored_chip", int'(chip), int'(code[7][1]));

        cyc(1, 0, 12, 0, 0);
        repeat (500) cyc(0, 1, 12, 0, 0);
        chk("pre_rst_idx", int'(chip_idx), 500);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_idx", int'(chip_idx), 0);
        chk("mid_rst_running", int'(running), 0);
        chk("mid_rst_chip", int'(chip), 0);
        chk("mid_rst_epoch", int'(epoch), 0);
        repeat (3) cyc(0, 1, 12, 0, 0);
        chk("post_rst_idx", int'(chip_idx), 0);
        chk("post_rst_running", int'(running), 0);

        for (int t = 0; t < 4000; t++) begin
            rst = ($urandom_range(0, 799) == 0);
            cyc(running ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 9) == 0),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 31),
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 6));
            rst = 1'b0;
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1ca_code_gen.md
Name: l1ca_code_gen

Overview:
Generates the GPS L1 C/A Gold code for one satellite, one chip per chip_en strobe. It is the code-replica stage that directly feeds the channel correlator/accumulator, which consumes chip, chip_idx and epoch.
It supports a restart for a new SV and a code-phase slew that holds the code for N chip strobes during acquisition-to-tracking alignment.

Parameters:
CODE_LEN, 1023, chips per C/A epoch; the terminal chip_idx is CODE_LEN-1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: latch sv, reinitialise LFSRs, enter RUN
sv  in  sv_t (5)  satellite select; value n selects PRN n+1 (0..31 = PRN1..32)
chip_en  in  1  advance one chip (typically 1.023 MHz strobe)
slew_valid  in  1  slew request valid
slew_chips  in  gps_chip_t (10)  number of chip_en strobes to hold
slew_ready  out  1  high only in RUN; slew accepted when slew_valid && slew_ready
chip  out  1  current code chip (1 = logic one)
chip_idx  out  gps_chip_t  index of current chip, 0..1022
epoch  out  1  one-cycle pulse, coincident with chip_idx becoming 0 on an advance
running  out  1  high in RUN or SLEW

Behaviour:
- Reset: state IDLE; G1 = G2 = 10'b11_1111_1111; chip_idx = 0; chip = 0; epoch = 0; running = 0; slew_ready = 0; latched SV = 0.
- LFSRs use l1ca_lfsr_t [10:1]. Each shift moves bit k to k+1, and feedback enters bit 1.
  - G1 feedback: G1[3]^G1[10].
  - G2 feedback: G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10].
- chip = G1[10] ^ G2[a] ^ G2[b], where (a,b) is the IS-GPS-200 phase-selector pair for the latched PRN:
  - PRN 1-8: 2,6 3,7 4,8 5,9 1,9 2,10 1,8 2,9
  - PRN 9-16: 3,10 2,3 3,4 5,6 6,7 7,8 8,9 9,10
  - PRN 17-24: 1,4 2,5 3,6 4,7 5,8 6,9 1,3 4,6
  - PRN 25-32: 5,7 6,8 7,9 8,10 1,6 2,7 3,8 4,9
- chip is registered and always reflects the registered LFSR state.
- State machine:
  - IDLE: chip_en ignored; start -> RUN.
  - RUN: chip_en shifts both LFSRs and sets chip_idx <= chip_idx+1. At chip_idx = 1022, chip_en instead sets chip_idx <= 0, reloads both LFSRs to all-ones and asserts epoch for that one cycle.
  - RUN: an accepted slew with slew_chips = 0 is a no-op and stays in RUN. An accepted slew with N > 0 loads a hold counter with N and goes to SLEW.
  - SLEW: each chip_en decrements the hold counter with no code advance and no epoch; chip_idx is frozen. When the counter reaches 0 on a chip_en, go to RUN; the next chip_en advances normally. slew_ready = 0.
- Latency:
  - The cycle after start: chip_idx = 0, chip = first chip of the new PRN, running = 1.
  - Each chip_en updates the outputs on the following clock edge.
- Priority: rst > start > chip_en/slew.
  - start in any state (including SLEW) aborts the current activity and reinitialises; a chip_en or slew_valid in the same cycle is discarded.
  - In RUN, slew acceptance and chip_en in the same cycle: the chip advance happens, then the slew counter starts, so the hold applies to subsequent strobes.
- Changes on sv without start have no effect.
- Back-to-back chip_en on consecutive cycles is legal; every strobe is honoured.
- rst mid-operation returns every output to its reset value on the next edge.

Decomposition:
- Add to common_gnss_types_pkg:
  - L1CA_CODE_LEN = 1023
  - L1CA_LFSR_INIT = all ones
  - typedef g2_tap_t (pair of 4-bit tap indices)
  - function l1ca_g2_taps(sv_t) returning the tap pair
- One natural sub-module: l1ca_lfsr (parameterised feedback mask, load-init, shift-enable), instantiated twice for G1 and G2.

Test Plan:
- rst, start with sv=0 (PRN1), then 10 chip_en. The chip sequence read after start and each strobe is 1,1,0,0,1,0,0,0,0,0 (octal 1440). chip_idx reaches 10.
- start with sv=1, 2 and 3. The first 10 chips are octal 1620, 1710 and 1744 respectively.
- PRN1, 1023 chip_en:
  - epoch pulses exactly once, coincident with chip_idx=0.
  - The following 1023 chips are identical to the first period.
  - Full sequences for all 32 PRNs match the golden model.
- In RUN at chip_idx=5, slew_chips=3 with slew_valid:
  - slew_ready drops.
  - The next 3 chip_en leave chip_idx=5 and chip unchanged.
  - The 4th chip_en gives chip_idx=6, and slew_ready returns.
- start asserted with chip_en in the same cycle, and again during SLEW: chip_idx=0, first chip of the new PRN, state RUN, no epoch pulse.
- rst asserted at chip_idx=500: all outputs take their reset values the next cycle, and chip_en is ignored until start.
